// File: rtl/formula_sum_isqrt_pkg.sv
// rtl/formula_sum_isqrt_pkg.sv - shared types and defaults for the sum-of-isqrt formula block
package formula_sum_isqrt_pkg;

  localparam int DEF_N_ARGS = 3;
  localparam int DEF_X_W    = 32;
  localparam int DEF_Y_W    = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/isqrt_result_accumulator.sv
// rtl/isqrt_result_accumulator.sv - sums N_ARGS in-order isqrt results into one strobed result
module isqrt_result_accumulator #(
  parameter int N_ARGS = 3,
  parameter int Y_W    = 16,
  parameter int RES_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_vld,
  input  logic [Y_W-1:0]   y,
  output logic             res_vld,
  output logic [RES_W-1:0] res
);

  localparam int CNT_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;

  logic [RES_W-1:0] acc;
  logic [CNT_W-1:0] rcnt;
  logic [RES_W-1:0] sum;

  assign sum = acc + RES_W'(y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      rcnt    <= '0;
      res     <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      if (y_vld) begin
        if (rcnt == CNT_W'(N_ARGS - 1)) begin
          res     <= sum;
          res_vld <= 1'b1;
          acc     <= '0;
          rcnt    <= '0;
        end else begin
          acc  <= sum;
          rcnt <= rcnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/formula_sum_isqrt_pipe_aware_fsm.sv
// rtl/formula_sum_isqrt_pipe_aware_fsm.sv - issues argument sets to an external pipelined isqrt and sums results
// Optional protocol checker: FORMULA_SUM_ISQRT_PROTOCOL_CHECK_EN
module formula_sum_isqrt_pipe_aware_fsm
  import formula_sum_isqrt_pkg::*;
#(
  parameter int N_ARGS = DEF_N_ARGS,
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int RES_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arg_vld,
  output logic                    arg_rdy,
  input  logic [N_ARGS*X_W-1:0]   args,
  output logic                    res_vld,
  output logic [RES_W-1:0]        res,
  output logic                    isqrt_x_vld,
  output logic [X_W-1:0]          isqrt_x,
`ifdef FORMULA_SUM_ISQRT_PROTOCOL_CHECK_EN
  output logic                    proto_err,
`endif
  input  logic                    isqrt_y_vld,
  input  logic [Y_W-1:0]          isqrt_y
);

  localparam int IDX_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;

  if (RES_W < Y_W + $clog2(N_ARGS)) begin : g_res_w_check
    $error("RES_W too narrow to hold the sum of N_ARGS isqrt results");
  end

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [N_ARGS*X_W-1:0]   args_q;
  logic                    accept;

  assign accept = arg_vld && arg_rdy;

  // arg[0] goes straight to the isqrt on the accept cycle; the rest come from args_q.
  always_comb begin
    arg_rdy     = (state == ST_IDLE);
    isqrt_x_vld = 1'b0;
    isqrt_x     = args[X_W-1:0];
    if (state == ST_ISSUE) begin
      isqrt_x_vld = 1'b1;
      isqrt_x     = args_q[idx*X_W +: X_W];
    end else if (arg_vld) begin
      isqrt_x_vld = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      args_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            args_q <= args;
            idx    <= IDX_W'(1);
            if (N_ARGS > 1) state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (idx == IDX_W'(N_ARGS - 1)) begin
            idx   <= '0;
            state <= ST_IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The accumulator relies on the isqrt returning results in issue order.
  isqrt_result_accumulator #(
    .N_ARGS (N_ARGS),
    .Y_W    (Y_W),
    .RES_W  (RES_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .y_vld   (isqrt_y_vld),
    .y       (isqrt_y),
    .res_vld (res_vld),
    .res     (res)
  );

`ifdef FORMULA_SUM_ISQRT_PROTOCOL_CHECK_EN
  localparam int OUT_W = $clog2(N_ARGS*64 + 1);

  logic [OUT_W-1:0] outstanding;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (isqrt_y_vld && outstanding == '0) proto_err <= 1'b1;
      if (isqrt_x_vld && !isqrt_y_vld && outstanding == '1) proto_err <= 1'b1;
      if (isqrt_x_vld && !isqrt_y_vld && outstanding != '1) begin
        outstanding <= outstanding + OUT_W'(1);
      end else if (!isqrt_x_vld && isqrt_y_vld && outstanding != '0) begin
        outstanding <= outstanding - OUT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_formula_sum_isqrt_pipe_aware_fsm.sv
// tb/tb_formula_sum_isqrt_pipe_aware_fsm.sv - bench for formula_sum_isqrt_pipe_aware_fsm (N_ARGS 3, 1, 4)
// Exercises FORMULA_SUM_ISQRT_PROTOCOL_CHECK_EN when defined
module tb_formula_sum_isqrt_pipe_aware_fsm;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Index 0: N_ARGS=3, 1: N_ARGS=1, 2: N_ARGS=4
  logic         av[3], ar[3], rv[3], xv[3], yv[3], inj[3];
  logic [127:0] ag[3];
  logic [31:0]  r[3], xx[3];
  logic [15:0]  yy[3];
  logic [L-1:0] pv[3];
  logic [15:0]  py[3][L];
`ifdef FORMULA_SUM_ISQRT_PROTOCOL_CHECK_EN
  logic         pe[3];
`endif

  typedef struct {
    int     d;
    longint sum;
    int     due;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [31:0] a0, a1, a2;
    logic [31:0] exp_res;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint isqrt(input longint v);
    longint s;
    s = longint'($sqrt(real'(v)));
    while (s * s > v) s--;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  function automatic int nargs(input int d);
    return (d == 0) ? 3 : (d == 1) ? 1 : 4;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    ag[0] = {32'd0, c, b, a};
  endtask

  task automatic wait_res(input int d, output logic [31:0] val, output int at);
    at  = -1;
    val = 'x;
    for (int i = 0; i < 40; i++) begin
      if (rv[d]) begin
        at  = cyc;
        val = r[d];
        return;
      end
      tick();
    end
    chk("res_timeout", 64'd0, 64'd1);
  endtask

  formula_sum_isqrt_pipe_aware_fsm #(.N_ARGS(3), .X_W(32), .Y_W(16), .RES_W(32)) u_n3 (
    .clk(clk), .rst(rst), .arg_vld(av[0]), .arg_rdy(ar[0]), .args(ag[0][95:0]),
    .res_vld(rv[0]), .res(r[0]), .isqrt_x_vld(xv[0]), .isqrt_x(xx[0]),
`ifdef FORMULA_SUM_ISQRT_PROTOCOL_CHECK_EN
    .proto_err(pe[0]),
`endif
    .isqrt_y_vld(yv[0]), .isqrt_y(yy[0]));

  formula_sum_isqrt_pipe_aware_fsm #(.N_ARGS(1), .X_W(32), .Y_W(16), .RES_W(32)) u_n1 (
    .clk(clk), .rst(rst), .arg_vld(av[1]), .arg_rdy(ar[1]), .args(ag[1][31:0]),
    .res_vld(rv[1]), .res(r[1]), .isqrt_x_vld(xv[1]), .isqrt_x(xx[1]),
`ifdef FORMULA_SUM_ISQRT_PROTOCOL_CHECK_EN
    .proto_err(pe[1]),
`endif
    .isqrt_y_vld(yv[1]), .isqrt_y(yy[1]));

  formula_sum_isqrt_pipe_aware_fsm #(.N_ARGS(4), .X_W(32), .Y_W(16), .RES_W(32)) u_n4 (
    .clk(clk), .rst(rst), .arg_vld(av[2]), .arg_rdy(ar[2]), .args(ag[2]),
    .res_vld(rv[2]), .res(r[2]), .isqrt_x_vld(xv[2]), .isqrt_x(xx[2]),
`ifdef FORMULA_SUM_ISQRT_PROTOCOL_CHECK_EN
    .proto_err(pe[2]),
`endif
    .isqrt_y_vld(yv[2]), .isqrt_y(yy[2]));

  // Pipelined isqrt model, latency L, shared reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) pv[d] <= '0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        pv[d]    <= {pv[d][L-2:0], xv[d]};
        py[d][0] <= 16'(isqrt(longint'(xx[d])));
        for (int i = 1; i < L; i++) py[d][i] <= py[d][i-1];
      end
    end
  end

  assign yv[0] = pv[0][L-1] | inj[0];
  assign yv[1] = pv[1][L-1] | inj[1];
  assign yv[2] = pv[2][L-1] | inj[2];
  assign yy[0] = py[0][L-1];
  assign yy[1] = py[1][L-1];
  assign yy[2] = py[2][L-1];

  // Scoreboard: every accepted set yields its sum of square roots N_ARGS+L cycles later
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      for (int d = 0; d < 3; d++) begin
        int     f;
        longint s;
        if (av[d] && ar[d]) begin
          s = 0;
          for (int i = 0; i < nargs(d); i++) s += isqrt(longint'(ag[d][i*32 +: 32]));
          q.push_back('{d, s, cyc + nargs(d) + L});
        end
        f = -1;
        for (int k = 0; k < q.size(); k++) begin
          if (q[k].d == d) begin
            f = k;
            break;
          end
        end
        if (rv[d]) begin
          if (f < 0) begin
            chk("mon_stray_strobe", 64'd1, 64'd0);
          end else begin
            chk("mon_res", 64'(r[d]), 64'(q[f].sum));
            chk("mon_latency", 64'(cyc), 64'(q[f].due));
            q.delete(f);
          end
        end else if (f >= 0 && q[f].due <= cyc) begin
          chk("mon_missing_strobe", 64'd0, 64'd1);
          q.delete(f);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] val, val2;
    int          t0, at, at2;
    logic        rdy_pat[6];

    vecs[0] = '{32'd16, 32'd81, 32'd144, 32'd25};
    vecs[1] = '{32'd4, 32'd9, 32'd16, 32'd9};
    vecs[2] = '{32'd100, 32'd0, 32'd1, 32'd11};
    vecs[3] = '{32'd25, 32'd25, 32'd25, 32'd15};
    vecs[4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    vecs[5] = '{32'd2, 32'd3, 32'd8, 32'd4};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd196605};
    vecs[7] = '{32'd99, 32'd120, 32'd15, 32'd22};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      av[d]  = 1'b0;
      ag[d]  = '0;
      inj[d] = 1'b0;
    end
    repeat (2) tick();
    chk("rst_res_vld", 64'(rv[0]), 64'd0);
    chk("rst_res", 64'(r[0]), 64'd0);
    chk("rst_arg_rdy", 64'(ar[0]), 64'd1);
    chk("rst_x_vld", 64'(xv[0]), 64'd0);
    rst = 1'b0;
    tick();

    // Single set: issue order and latency
    av[0] = 1'b1;
    set3(32'd16, 32'd81, 32'd144);
    t0 = cyc;
    #1;
    chk("s1_rdy0", 64'(ar[0]), 64'd1);
    chk("s1_xv0", 64'(xv[0]), 64'd1);
    chk("s1_x0", 64'(xx[0]), 64'd16);
    tick();
    av[0] = 1'b0;
    #1;
    chk("s1_rdy1", 64'(ar[0]), 64'd0);
    chk("s1_x1", 64'(xx[0]), 64'd81);
    tick();
    chk("s1_xv2", 64'(xv[0]), 64'd1);
    chk("s1_x2", 64'(xx[0]), 64'd144);
    tick();
    chk("s1_xv_done", 64'(xv[0]), 64'd0);
    chk("s1_rdy_done", 64'(ar[0]), 64'd1);
    wait_res(0, val, at);
    chk("s1_res", 64'(val), 64'd25);
    chk("s1_latency", 64'(at - t0), 64'd7);
    tick();
    chk("s1_strobe_len", 64'(rv[0]), 64'd0);
    chk("s1_res_hold", 64'(r[0]), 64'd25);

    // Back-to-back sets with arg_vld held high
    for (int c = 0; c < 6; c++) begin
      av[0] = 1'b1;
      if (c < 3) set3(32'd4, 32'd9, 32'd16);
      else       set3(32'd100, 32'd0, 32'd1);
      if (c == 0) t0 = cyc;
      #1;
      chk("b2b_arg_rdy", 64'(ar[0]), 64'(rdy_pat[c]));
      tick();
    end
    av[0] = 1'b0;
    wait_res(0, val, at);
    tick();
    wait_res(0, val2, at2);
    chk("b2b_res_a", 64'(val), 64'd9);
    chk("b2b_res_b", 64'(val2), 64'd11);
    chk("b2b_lat_a", 64'(at - t0), 64'd7);
    chk("b2b_gap", 64'(at2 - at), 64'd3);
    repeat (2) tick();

    // Table of single sets with known answers
    for (int v = 0; v < 8; v++) begin
      av[0] = 1'b1;
      set3(vecs[v].a0, vecs[v].a1, vecs[v].a2);
      t0 = cyc;
      tick();
      av[0] = 1'b0;
      wait_res(0, val, at);
      chk("tbl_res", 64'(val), 64'(vecs[v].exp_res));
      chk("tbl_latency", 64'(at - t0), 64'd7);
      repeat (2) tick();
    end

    // N_ARGS=1: one set per cycle
    for (int c = 0; c < 4; c++) begin
      av[1] = 1'b1;
      ag[1] = 128'((c + 1) * (c + 1));
      if (c == 0) t0 = cyc;
      tick();
    end
    av[1] = 1'b0;
    wait_res(1, val, at);
    chk("n1_res0", 64'(val), 64'd1);
    chk("n1_latency", 64'(at - t0), 64'(L + 1));
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("n1_vld_run", 64'(rv[1]), 64'd1);
      chk("n1_res_run", 64'(r[1]), 64'(k + 1));
    end

    // N_ARGS=4: widest sum, no truncation
    av[2] = 1'b1;
    ag[2] = '1;
    t0 = cyc;
    tick();
    av[2] = 1'b0;
    wait_res(2, val, at);
    chk("n4_res_max", 64'(val), 64'd262140);
    chk("n4_latency", 64'(at - t0), 64'd8);
    repeat (2) tick();

    // Randomised traffic on all three instances against the scoreboard
    for (int c = 0; c < 300; c++) begin
      for (int d = 0; d < 3; d++) begin
        av[d] = ($urandom_range(0, 2) != 0);
        ag[d] = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
    end
    for (int d = 0; d < 3; d++) av[d] = 1'b0;
    repeat (20) tick();
    chk("rand_drained", 64'(q.size()), 64'd0);

    // Asynchronous reset after the second issue of a set
    av[0] = 1'b1;
    set3(32'd16, 32'd81, 32'd144);
    tick();
    av[0] = 1'b0;
    wait_res(0, val, at);
    chk("pre_rst_res", 64'(val), 64'd25);
    tick();
    av[0] = 1'b1;
    set3(32'd1000000, 32'd1000000, 32'd1000000);
    tick();
    av[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_res_vld", 64'(rv[0]), 64'd0);
    chk("arst_res", 64'(r[0]), 64'd0);
    chk("arst_arg_rdy", 64'(ar[0]), 64'd1);
    chk("arst_x_vld", 64'(xv[0]), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    av[0] = 1'b1;
    set3(32'd25, 32'd25, 32'd25);
    t0 = cyc;
    tick();
    av[0] = 1'b0;
    wait_res(0, val, at);
    chk("post_rst_res", 64'(val), 64'd15);
    chk("post_rst_latency", 64'(at - t0), 64'd7);
    repeat (12) tick();
    chk("post_rst_drained", 64'(q.size()), 64'd0);

`ifdef FORMULA_SUM_ISQRT_PROTOCOL_CHECK_EN
    chk("proto_clear", 64'(pe[0]), 64'd0);
    inj[0] = 1'b1;
    tick();
    inj[0] = 1'b0;
    #1;
    chk("proto_set", 64'(pe[0]), 64'd1);
    repeat (3) tick();
    chk("proto_sticky", 64'(pe[0]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("proto_rst", 64'(pe[0]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
